audio_adc_deserializer: RTL



---
 rtl/audio_adc_deserializer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/audio_adc_deserializer.sv
// -----------------------------------------------------------------------------
// audio_adc_deserializer
//
// Purpose:
//   Front end for the audio effect chain. Oversamples the codec ADC I2S stream
//   (BCLK, ADCLRCK, ADCDAT) in the CLOCK_50 domain, deserializes one
//   SAMPLE_WIDTH word per channel (MSB first, I2S one-bit delay) and presents
//   a coherent signed left/right pair with a one-cycle sampleValid strobe.
//
// Optional feature:
//   ADC_MONO_MIX_EN - when defined, adds monoSampleOut = (left + right) >>> 1,
//   updated together with the L/R pair. When undefined the port and adder
//   do not exist.
//
// Ports:
//   CLOCK_50        in   system clock, at least 8x BCLK
//   RESET_N         in   asynchronous active-low reset
//   BCLK            in   codec bit clock (asynchronous)
//   ADCLRCK         in   codec frame clock, low = left, high = right
//   ADCDAT          in   codec serial data
//   leftSampleOut   out  signed left sample, held until next pair
//   rightSampleOut  out  signed right sample, held until next pair
//   monoSampleOut   out  (ADC_MONO_MIX_EN only) averaged mono sample
//   sampleValid     out  one-cycle pulse when a full L/R pair is updated
//   frameError      out  one-cycle pulse on a truncated word or channel resync
//   o_fsm_state     out  current capture state (IDLE=0, SKIP=1, SHIFT=2, WAIT=3)
// -----------------------------------------------------------------------------
module audio_adc_deserializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    BCLK,
  input  logic                    ADCLRCK,
  input  logic                    ADCDAT,
  output logic [SAMPLE_WIDTH-1:0] leftSampleOut,
  output logic [SAMPLE_WIDTH-1:0] rightSampleOut,
`ifdef ADC_MONO_MIX_EN
  output logic [SAMPLE_WIDTH-1:0] monoSampleOut,
`endif
  output logic                    sampleValid,
  output logic                    frameError,
  output logic [1:0]              o_fsm_state
);

  localparam int CNT_W = (SAMPLE_WIDTH > 2) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SKIP  = 2'd1,
    S_SHIFT = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_chan, w_chan_nxt;          // 0 = left, 1 = right

  // Synchronizers and edge detect
  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lr_sync, r_dat_sync;
  logic                   r_bclk_d, r_lr_d;
  logic                   w_bclk_rise, w_lr_rise, w_lr_fall, w_lr_edge, w_dat;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_dat_sync  <= '0;
      r_bclk_d    <= 1'b0;
      r_lr_d      <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], BCLK};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], ADCLRCK};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], ADCDAT};
      r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
      r_lr_d      <= r_lr_sync[SYNC_STAGES-1];
    end
  end

  assign w_bclk_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_d;
  assign w_lr_rise   = r_lr_sync[SYNC_STAGES-1] & ~r_lr_d;
  assign w_lr_fall   = ~r_lr_sync[SYNC_STAGES-1] & r_lr_d;
  assign w_lr_edge   = w_lr_rise | w_lr_fall;
  // Data taken from the same stage that feeds the BCLK edge detect, so the
  // bit seen on a bclkRise pulse is the bit the codec presented at that edge.
  assign w_dat       = r_dat_sync[SYNC_STAGES-1];

  // Datapath registers
  logic [SAMPLE_WIDTH-1:0] r_shift, r_left_hold, w_word;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_left_pend;

  assign w_word = {r_shift[SAMPLE_WIDTH-2:0], w_dat};

  // Control strobes from the FSM
  logic w_cnt_clr, w_shift_en, w_latch_l, w_latch_r, w_err;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_chan  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  // LRCK edges are tested before bclkRise everywhere, so a coincident BCLK
  // edge is absorbed by the transition into SKIP.
  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_latch_l   = 1'b0;
    w_latch_r   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lr_fall) begin
          w_state_nxt = S_SKIP;
          w_chan_nxt  = 1'b0;
        end
      end
      S_SKIP: begin
        if (w_lr_edge) begin
          w_err       = 1'b1;
          w_state_nxt = S_SKIP;
          w_chan_nxt  = w_lr_rise;
        end else if (w_bclk_rise) begin
          w_state_nxt = S_SHIFT;
          w_cnt_clr   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_lr_edge) begin
          w_err       = 1'b1;
          w_state_nxt = S_SKIP;
          w_chan_nxt  = w_lr_rise;
        end else if (w_bclk_rise) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = S_WAIT;
            w_latch_l   = ~r_chan;
            w_latch_r   = r_chan;
          end
        end
      end
      S_WAIT: begin
        // Surplus slot bits are ignored; only the channel boundary matters.
        if (w_lr_rise) begin
          if (!r_chan) begin
            w_state_nxt = S_SKIP;
            w_chan_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end else if (w_lr_fall) begin
          if (r_chan) begin
            w_state_nxt = S_SKIP;
            w_chan_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_fsm_state = r_state;

`ifdef ADC_MONO_MIX_EN
  // Sign-extended sum at SAMPLE_WIDTH+1 bits; dropping bit 0 is the >>> 1.
  logic [SAMPLE_WIDTH:0] w_mono_sum;
  assign w_mono_sum = {r_left_hold[SAMPLE_WIDTH-1], r_left_hold} +
                      {w_word[SAMPLE_WIDTH-1], w_word};
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_left_hold    <= '0;
      r_left_pend    <= 1'b0;
      leftSampleOut  <= '0;
      rightSampleOut <= '0;
`ifdef ADC_MONO_MIX_EN
      monoSampleOut  <= '0;
`endif
      sampleValid    <= 1'b0;
      frameError     <= 1'b0;
    end else begin
      sampleValid <= w_latch_r & r_left_pend;
      frameError  <= w_err;
      if (w_shift_en) r_shift <= w_word;
      if (w_cnt_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_latch_l) r_left_hold <= w_word;
      // A left word is only paired with the right word that directly follows
      // it; any error in between drops the pending left.
      if (w_latch_l)                  r_left_pend <= 1'b1;
      else if (w_latch_r || w_err)    r_left_pend <= 1'b0;
      if (w_latch_r && r_left_pend) begin
        leftSampleOut  <= r_left_hold;
        rightSampleOut <= w_word;
`ifdef ADC_MONO_MIX_EN
        monoSampleOut  <= w_mono_sum[SAMPLE_WIDTH:1];
`endif
      end
    end
  end

endmodule
